clk_divider_mc: RTL and testbench
=================================

# clk_divider_mc

Multi-channel, runtime-programmable clock divider for the pipeline CPU clock tree. It replaces the fixed divide-by-10 prescaler with `NUM_CH` independent channels. Each channel has a programmable half-period, a selectable mode (off / square wave / single-cycle tick / debug single-step), and glitch-free reconfiguration applied only at period boundaries. All logic runs in the `clk_in` domain; outputs feed CPU clock and enable inputs and debug step control.

## Interface
- `NUM_CH`, 2, number of independent channels (1..8)
- `CNT_W`, 32, width of divisor and counter
- `DEFAULT_DIV`, 5, reset half-period in `clk_in` cycles for all channels
- `RESET_MODE`, 2'b01, reset mode for all channels
- `clk_in`  in  1  system clock (50 MHz); the only clock
- `reset`  in  1  asynchronous, active-high reset
- `cfg_we`  in  1  config write strobe, one cycle
- `cfg_ch`  in  $clog2(NUM_CH) (min 1)  target channel; writes with `cfg_ch >= NUM_CH` are ignored
- `cfg_div`  in  CNT_W  new half-period; 0 is treated as 1
- `cfg_mode`  in  2  00 off, 01 toggle, 10 pulse, 11 step
- `step_req`  in  NUM_CH  per-channel single-step request, level-sampled
- `clk_out`  out  NUM_CH  divided clock per channel, registered
- `tick`  out  NUM_CH  one-cycle pulse at each terminal count, registered
- `cfg_pending`  out  NUM_CH  a written config is waiting for its boundary
- `step_busy`  out  NUM_CH  a single-step period is in progress

## Operation
- Per-channel state: `div`, `mode`, `count`, pending `div`/`mode`, `pend` flag, step FSM (IDLE, HIGH, LOW).
- Terminal count (TC): a `clk_in` edge with an active counter and `count == eff_div-1`, where `eff_div = max(div,1)`. At TC, `count` is set to 0; otherwise `count` increments.
- Toggle: the counter runs continuously. At TC, `clk_out` inverts and `tick` is 1 for one cycle. The period is 2·`eff_div`; the duty cycle is exactly 50%.
- Pulse: the counter runs continuously and `tick` fires at every TC (period `eff_div`). `clk_out` mirrors `tick`.
- Off: the counter is held at 0, and `clk_out` and `tick` are 0.
- Step:
  - IDLE: `clk_out`=0 and the counter is held. When `step_req` is 1, the FSM moves to HIGH, `clk_out` goes to 1, `step_busy` goes to 1, and `count` restarts at 0.
  - HIGH: at TC, the FSM moves to LOW and `clk_out` goes to 0.
  - LOW: at TC, the FSM returns to IDLE, `step_busy` goes to 0, and `tick` pulses once.
  - `step_req` is ignored while busy. A request held high re-triggers from IDLE one cycle after the previous step completes.
- Config write: `cfg_div`/`cfg_mode` are latched into the pending register and `pend` is set. A second write before apply overwrites the pending values.
- Apply point (pending values copied, `pend` cleared, `count`←0):
  - Toggle: the TC at which `clk_out` falls 1→0.
  - Pulse: any TC.
  - Off, or step IDLE: the next edge after the write.
  - Step HIGH/LOW: end of the step (transition to IDLE).
- A write and an apply point on the same edge: the new write wins. `pend` stays 1 and the apply is deferred to the next boundary.
- The channel always enters its new mode with `clk_out`=0. No runt high or low phase is ever produced.
- Channels are fully independent. A write to one channel never perturbs another.

## Timing
- Reset (async assert, sync release by edge): every channel has `div`=`DEFAULT_DIV`, `mode`=`RESET_MODE`, `count`=0, `clk_out`=0, `tick`=0, `cfg_pending`=0, `step_busy`=0, and FSM in IDLE.
- Toggle with `eff_div`=D after reset release: the first `clk_out` rise is on the D-th edge, the first fall on the 2D-th edge, and so on.
- `tick` is high for exactly one `clk_in` cycle, in the cycle following TC, coincident with the `clk_out` change.
- `cfg_pending` rises the edge after `cfg_we` and falls on the apply edge.
- Step latency: `clk_out` rises on the edge sampling `step_req`=1 in IDLE. It stays high D cycles and low D cycles; `step_busy` falls on the 2D-th edge.
- Reset mid-period or mid-step: outputs clear immediately (asynchronously) and pending config is discarded.
- The counter never wraps unintentionally, because `count < eff_div ≤ 2^CNT_W-1` always holds.

## Test plan
- Reset, default params (D=5, toggle) → `clk_out` period 10 cycles, high 5/low 5; `tick` pulses every 5 cycles; all other outputs 0.
- With `clk_out`=1 mid-high-phase, write ch0 `div`=3 → `cfg_pending`=1 until the 1→0 fall; then period 6; no phase shorter than 3.
- Write `cfg_div`=0 in pulse mode → `tick` every cycle, `clk_out`==`tick`; write `div`=1 in toggle → `clk_out` toggles every cycle.
- Step mode, D=4, one-cycle `step_req` → `clk_out` high 4, low 4, `step_busy` 8 cycles, one `tick`; a second `step_req` during busy → ignored.
- Write ch1 while ch0 runs at D=5 → ch0 waveform unchanged cycle-for-cycle; a write with `cfg_ch`=`NUM_CH` → no channel changes.
- Assert `reset` mid-step with pending config → all outputs 0 immediately; after release, defaults resume (period 10) and the pending value is lost.

Source files
------------

// File: rtl/clk_divider_mc.sv
// Multi-channel runtime-programmable clock divider (off / toggle / pulse / single-step).
// Each channel buffers config writes and applies them only at a period boundary.
module clk_divider_mc #(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 5,
  parameter logic [1:0]  RESET_MODE  = 2'b01,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] step_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] step_busy
);

  typedef enum logic [1:0] {MODE_OFF, MODE_TOGGLE, MODE_PULSE, MODE_STEP} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} step_e;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

    logic [CNT_W-1:0] div_q, div_d, pdiv_q, pdiv_d, count_q, count_d, eff_div;
    mode_e            mode_q, mode_d, pmode_q, pmode_d;
    step_e            st_q, st_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic             wr, tc, boundary;

    // Writes aimed at a nonexistent channel never match any CH_IDX.
    assign wr      = cfg_we && (cfg_ch == CH_IDX);
    assign eff_div = (div_q == '0) ? CNT_W'(1) : div_q;
    assign tc      = (count_q == eff_div - CNT_W'(1));

    always_comb begin
      div_d    = div_q;
      mode_d   = mode_q;
      pdiv_d   = pdiv_q;
      pmode_d  = pmode_q;
      pend_d   = pend_q;
      st_d     = st_q;
      count_d  = count_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      boundary = 1'b0;

      unique case (mode_q)
        MODE_OFF: begin
          count_d  = '0;
          clk_d    = 1'b0;
          boundary = 1'b1;
        end
        MODE_TOGGLE: begin
          if (tc) begin
            count_d  = '0;
            clk_d    = ~clk_q;
            tick_d   = 1'b1;
            boundary = clk_q;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        MODE_PULSE: begin
          clk_d  = tc;
          tick_d = tc;
          if (tc) begin
            count_d  = '0;
            boundary = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        MODE_STEP: begin
          case (st_q)
            ST_IDLE: begin
              clk_d    = 1'b0;
              boundary = 1'b1;
              if (step_req[g]) begin
                st_d    = ST_HIGH;
                clk_d   = 1'b1;
                count_d = '0;
              end
            end
            ST_HIGH: begin
              if (tc) begin
                st_d    = ST_LOW;
                clk_d   = 1'b0;
                count_d = '0;
              end else begin
                count_d = count_q + CNT_W'(1);
              end
            end
            ST_LOW: begin
              if (tc) begin
                st_d     = ST_IDLE;
                tick_d   = 1'b1;
                count_d  = '0;
                boundary = 1'b1;
              end else begin
                count_d = count_q + CNT_W'(1);
              end
            end
            default: st_d = ST_IDLE;
          endcase
        end
      endcase

      // A fresh write on a boundary edge wins; the apply waits for the next boundary.
      if (wr) begin
        pdiv_d  = cfg_div;
        pmode_d = mode_e'(cfg_mode);
        pend_d  = 1'b1;
      end else if (pend_q && boundary) begin
        div_d   = pdiv_q;
        mode_d  = pmode_q;
        pend_d  = 1'b0;
        count_d = '0;
        clk_d   = 1'b0;
        st_d    = ST_IDLE;
      end
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        div_q   <= CNT_W'(DEFAULT_DIV);
        mode_q  <= mode_e'(RESET_MODE);
        pdiv_q  <= CNT_W'(DEFAULT_DIV);
        pmode_q <= mode_e'(RESET_MODE);
        pend_q  <= 1'b0;
        st_q    <= ST_IDLE;
        count_q <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        div_q   <= div_d;
        mode_q  <= mode_d;
        pdiv_q  <= pdiv_d;
        pmode_q <= pmode_d;
        pend_q  <= pend_d;
        st_q    <= st_d;
        count_q <= count_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    assign clk_out[g]     = clk_q;
    assign tick[g]        = tick_q;
    assign cfg_pending[g] = pend_q;
    assign step_busy[g]   = (st_q != ST_IDLE);
  end

endmodule

// File: tb/tb_clk_divider_mc.sv
// Directed self-checking bench for clk_divider_mc with three channels.
module tb_clk_divider_mc;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 32;

   logic              clk_in = 1'b0;
   logic              reset;
   logic              cfg_we;
   logic [1:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [1:0]        cfg_mode;
   logic [NUM_CH-1:0] step_req;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] cfg_pending;
   logic [NUM_CH-1:0] step_busy;

   int checkCount = 0;
   int failCount  = 0;
   int edgeNo     = 0;

   // Expected-waveform description per channel: mode (1 toggle, 2 pulse), half-period, start edge
   int                tbMode  [NUM_CH];
   int                tbD     [NUM_CH];
   int                tbStart [NUM_CH];
   logic [NUM_CH-1:0] activeMask = '0;

   clk_divider_mc #(
      .NUM_CH(NUM_CH),
      .CNT_W (CNT_W)
   ) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_mode   (cfg_mode),
      .step_req   (step_req),
      .clk_out    (clk_out),
      .tick       (tick),
      .cfg_pending(cfg_pending),
      .step_busy  (step_busy)
   );

   always #5 clk_in = ~clk_in;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive a config write; it is latched on the next rising edge
   task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] div, input logic [1:0] mode);
      cfg_we   = 1'b1;
      cfg_ch   = ch;
      cfg_div  = div;
      cfg_mode = mode;
   endtask

   task automatic endWrite();
      cfg_we = 1'b0;
   endtask

   task automatic setModel(input int ch, input int mode, input int d, input int start);
      tbMode[ch]     = mode;
      tbD[ch]        = d;
      tbStart[ch]    = start;
      activeMask[ch] = 1'b1;
   endtask

   // Advance one edge, then compare every modelled channel against its closed-form waveform
   task automatic stepEdge();
      int   m;
      logic expC, expT;
      @(posedge clk_in);
      #1;
      edgeNo++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (activeMask[ch]) begin
            m    = edgeNo - tbStart[ch];
            expT = (m > 0) && ((m % tbD[ch]) == 0);
            if (tbMode[ch] == 1) expC = (((m / tbD[ch]) % 2) == 1);
            else                 expC = expT;
            checkOutput($sformatf("clk_out%0d@%0d", ch, edgeNo), 32'(clk_out[ch]), 32'(expC));
            checkOutput($sformatf("tick%0d@%0d", ch, edgeNo), 32'(tick[ch]), 32'(expT));
         end
      end
   endtask

   task automatic runEdges(input int n);
      for (int i = 0; i < n; i++) stepEdge();
   endtask

   initial begin
      reset    = 1'b1;
      cfg_we   = 1'b0;
      cfg_ch   = '0;
      cfg_div  = '0;
      cfg_mode = '0;
      step_req = '0;

      repeat (3) @(posedge clk_in);
      #1;
      checkOutput("rst_clk_out", 32'(clk_out), 32'h0);
      checkOutput("rst_tick", 32'(tick), 32'h0);
      checkOutput("rst_pending", 32'(cfg_pending), 32'h0);
      checkOutput("rst_busy", 32'(step_busy), 32'h0);

      // Defaults: every channel toggles with half-period 5
      reset  = 1'b0;
      edgeNo = 0;
      for (int ch = 0; ch < NUM_CH; ch++) setModel(ch, 1, 5, 0);
      runEdges(27);
      checkOutput("dflt_pending", 32'(cfg_pending), 32'h0);
      checkOutput("dflt_busy", 32'(step_busy), 32'h0);

      // ch0 mid-high-phase: div=3 waits for the fall at edge 30
      applyStimulus(2'd0, 32'd3, 2'b01);
      stepEdge();
      endWrite();
      checkOutput("div3_pending", 32'(cfg_pending), 32'h1);
      stepEdge();
      checkOutput("div3_pending_hold", 32'(cfg_pending), 32'h1);
      activeMask[0] = 1'b0;
      stepEdge();
      checkOutput("div3_apply_clk", 32'(clk_out[0]), 32'h0);
      checkOutput("div3_apply_tick", 32'(tick[0]), 32'h1);
      checkOutput("div3_apply_pend", 32'(cfg_pending), 32'h0);
      setModel(0, 1, 3, edgeNo);
      runEdges(12);

      // ch0 pulse with div=0 (treated as 1), applied at the fall on edge 48
      applyStimulus(2'd0, 32'd0, 2'b10);
      stepEdge();
      endWrite();
      checkOutput("pulse_pending", 32'(cfg_pending), 32'h1);
      runEdges(4);
      activeMask[0] = 1'b0;
      stepEdge();
      checkOutput("pulse_apply_clk", 32'(clk_out[0]), 32'h0);
      checkOutput("pulse_apply_tick", 32'(tick[0]), 32'h1);
      checkOutput("pulse_apply_pend", 32'(cfg_pending), 32'h0);
      setModel(0, 2, 1, edgeNo);
      runEdges(5);
      checkOutput("pulse_clk_eq_tick", 32'(clk_out[0]), 32'(tick[0]));

      // ch0 toggle with div=1: applied at the next pulse TC, then toggles every edge
      applyStimulus(2'd0, 32'd1, 2'b01);
      stepEdge();
      endWrite();
      activeMask[0] = 1'b0;
      stepEdge();
      checkOutput("div1_apply_clk", 32'(clk_out[0]), 32'h0);
      checkOutput("div1_apply_tick", 32'(tick[0]), 32'h1);
      setModel(0, 1, 1, edgeNo);
      runEdges(5);

      // ch1 to step mode D=4 while ch2 keeps running at D=5
      applyStimulus(2'd1, 32'd4, 2'b11);
      stepEdge();
      endWrite();
      checkOutput("step_pending", 32'(cfg_pending), 32'h2);
      runEdges(8);
      activeMask[1] = 1'b0;
      stepEdge();
      checkOutput("step_apply_clk", 32'(clk_out[1]), 32'h0);
      checkOutput("step_apply_tick", 32'(tick[1]), 32'h1);
      checkOutput("step_apply_pend", 32'(cfg_pending), 32'h0);
      for (int i = 0; i < 2; i++) begin
         stepEdge();
         checkOutput("step_idle_clk", 32'(clk_out[1]), 32'h0);
         checkOutput("step_idle_busy", 32'(step_busy[1]), 32'h0);
      end
      step_req = 3'b010;
      for (int m = 0; m < 10; m++) begin
         stepEdge();
         checkOutput($sformatf("step_clk_m%0d", m), 32'(clk_out[1]), 32'(m < 4));
         checkOutput($sformatf("step_busy_m%0d", m), 32'(step_busy[1]), 32'(m < 8));
         checkOutput($sformatf("step_tick_m%0d", m), 32'(tick[1]), 32'(m == 8));
         step_req = (m == 2) ? 3'b010 : 3'b000;
      end

      // Reset in the middle of a step with a pending config
      step_req = 3'b010;
      stepEdge();
      step_req = 3'b000;
      checkOutput("step2_busy", 32'(step_busy[1]), 32'h1);
      applyStimulus(2'd1, 32'd7, 2'b01);
      stepEdge();
      endWrite();
      stepEdge();
      checkOutput("step2_pending", 32'(cfg_pending), 32'h2);
      checkOutput("step2_clk_high", 32'(clk_out[1]), 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("async_clk_out", 32'(clk_out), 32'h0);
      checkOutput("async_tick", 32'(tick), 32'h0);
      checkOutput("async_pending", 32'(cfg_pending), 32'h0);
      checkOutput("async_busy", 32'(step_busy), 32'h0);
      @(posedge clk_in);
      #1;
      reset  = 1'b0;
      edgeNo = 0;
      for (int ch = 0; ch < NUM_CH; ch++) setModel(ch, 1, 5, 0);
      runEdges(3);

      // Write to a nonexistent channel must change nothing
      applyStimulus(2'd3, 32'd2, 2'b00);
      stepEdge();
      endWrite();
      checkOutput("badch_pending", 32'(cfg_pending), 32'h0);
      runEdges(16);
      checkOutput("final_busy", 32'(step_busy), 32'h0);
      checkOutput("final_pending", 32'(cfg_pending), 32'h0);

      $display("test done: total=%0d bad=%0d", checkCount, failCount);
      $finish;
   end

endmodule
